// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - shared encodings for the instruction-cycle controller
package cpu_ctrl_pkg;

   localparam int DW = 16;
   localparam logic [DW-1:0] DEFAULT_RESET_VECTOR = 16'h0000;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_VECTOR = 3'd1,
      ST_FETCH  = 3'd2,
      ST_WAIT   = 3'd3,
      ST_DECODE = 3'd4,
      ST_EXEC   = 3'd5,
      ST_UPDATE = 3'd6,
      ST_HALT   = 3'd7
   } state_e;

endpackage

// File: rtl/mem_timeout_timer.sv
// rtl/mem_timeout_timer.sv - counts consecutive enabled cycles, flags the MEM_TIMEOUT-th
module mem_timeout_timer #(
   parameter int MEM_TIMEOUT = 16
) (
   input  logic clk,
   input  logic rst_i,
   input  logic clear_i,
   input  logic enable_i,
   output logic expired_o
);

   localparam int CW     = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
   localparam int LAST_I = (MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0;
   localparam logic [CW-1:0] LAST = LAST_I[CW-1:0];

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear_i)
         cnt_d = '0;
      else if (enable_i && cnt_q != LAST)
         cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk or posedge rst_i) begin
      if (rst_i) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   // Combinational so the fault decision lands in the same cycle as the last WAIT.
   assign expired_o = (MEM_TIMEOUT != 0) && enable_i && (cnt_q == LAST);

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - fetch/decode/execute sequencer that owns the PC load port
module pc_sequencer
   import cpu_ctrl_pkg::*;
#(
   parameter logic [15:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
   parameter logic [15:0] PC_STEP      = 16'd1,
   parameter int          MEM_TIMEOUT  = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        halt_req,
   input  logic [15:0] pc_cur,
   output logic        mem_rd,
   output logic [15:0] mem_addr,
   input  logic        mem_ready,
   input  logic [15:0] mem_rdata,
   output logic [15:0] ir,
   output logic        ir_valid,
   input  logic        exec_done,
   input  logic        branch_taken,
   input  logic [15:0] branch_target,
   output logic        en_pc,
   output logic [15:0] in_pc,
   output logic [15:0] retired,
   output logic        halted,
   output logic        fault,
   output logic [2:0]  state
);

   state_e      state_q, state_d;
   logic [15:0] mem_addr_q, mem_addr_d;
   logic [15:0] ir_q, ir_d;
   logic [15:0] in_pc_q, in_pc_d;
   logic [15:0] retired_q, retired_d;
   logic        fault_q, fault_d;
   logic        halt_pending_q, halt_pending_d;
   logic        mem_rd_q, en_pc_q, ir_valid_q, halted_q;
   logic        tmo_expired;

   mem_timeout_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
      .clk       (clk),
      .rst_i     (reset),
      .clear_i   (state_q != ST_WAIT),
      .enable_i  (state_q == ST_WAIT),
      .expired_o (tmo_expired)
   );

   always_comb begin
      state_d        = state_q;
      mem_addr_d     = mem_addr_q;
      ir_d           = ir_q;
      in_pc_d        = in_pc_q;
      retired_d      = retired_q;
      fault_d        = fault_q;
      halt_pending_d = halt_pending_q;

      if (halt_req && state_q != ST_IDLE && state_q != ST_HALT)
         halt_pending_d = 1'b1;

      unique case (state_q)
         ST_IDLE: if (start) begin
            state_d        = ST_VECTOR;
            in_pc_d        = RESET_VECTOR;
            halt_pending_d = 1'b0;
         end
         ST_VECTOR: state_d = ST_FETCH;
         ST_FETCH: begin
            mem_addr_d = pc_cur;
            state_d    = ST_WAIT;
         end
         // mem_ready on the expiring cycle wins over the timeout.
         ST_WAIT: begin
            if (mem_ready) begin
               ir_d    = mem_rdata;
               state_d = ST_DECODE;
            end else if (tmo_expired) begin
               fault_d        = 1'b1;
               halt_pending_d = 1'b0;
               state_d        = ST_HALT;
            end
         end
         ST_DECODE: state_d = ST_EXEC;
         ST_EXEC: if (exec_done) begin
            in_pc_d = branch_taken ? branch_target : pc_cur + PC_STEP;
            state_d = ST_UPDATE;
         end
         ST_UPDATE: begin
            retired_d = retired_q + 16'd1;
            if (halt_pending_q || halt_req) begin
               halt_pending_d = 1'b0;
               state_d        = ST_HALT;
            end else begin
               state_d = ST_FETCH;
            end
         end
         ST_HALT: if (start && !fault_q) begin
            halt_pending_d = 1'b0;
            state_d        = ST_FETCH;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Strobes are registered from the next state so they align with the state they belong to.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q        <= ST_IDLE;
         mem_addr_q     <= '0;
         ir_q           <= '0;
         in_pc_q        <= '0;
         retired_q      <= '0;
         fault_q        <= 1'b0;
         halt_pending_q <= 1'b0;
         mem_rd_q       <= 1'b0;
         en_pc_q        <= 1'b0;
         ir_valid_q     <= 1'b0;
         halted_q       <= 1'b0;
      end else begin
         state_q        <= state_d;
         mem_addr_q     <= mem_addr_d;
         ir_q           <= ir_d;
         in_pc_q        <= in_pc_d;
         retired_q      <= retired_d;
         fault_q        <= fault_d;
         halt_pending_q <= halt_pending_d;
         mem_rd_q       <= (state_d == ST_WAIT);
         en_pc_q        <= (state_d == ST_VECTOR) || (state_d == ST_UPDATE);
         ir_valid_q     <= (state_d == ST_DECODE);
         halted_q       <= (state_d == ST_HALT);
      end
   end

   assign mem_rd   = mem_rd_q;
   assign mem_addr = mem_addr_q;
   assign ir       = ir_q;
   assign ir_valid = ir_valid_q;
   assign en_pc    = en_pc_q;
   assign in_pc    = in_pc_q;
   assign retired  = retired_q;
   assign halted   = halted_q;
   assign fault    = fault_q;
   assign state    = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - scoreboard bench for pc_sequencer with a program_counter model
module tb_pc_sequencer;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        halt_req = 1'b0;
   logic [15:0] pc_cur;
   logic        mem_rd;
   logic [15:0] mem_addr;
   logic        mem_ready = 1'b0;
   logic [15:0] mem_rdata = '0;
   logic [15:0] ir;
   logic        ir_valid;
   logic        exec_done = 1'b0;
   logic        branch_taken = 1'b0;
   logic [15:0] branch_target = '0;
   logic        en_pc;
   logic [15:0] in_pc;
   logic [15:0] retired;
   logic        halted;
   logic        fault;
   logic [2:0]  state;

   int n_tests = 0;
   int n_fail  = 0;
   int cycle   = 0;

   logic [15:0] pc_q_model;
   logic [15:0] exp_pc;
   logic [15:0] exp_retired;
   logic [15:0] pcload_q[$];
   logic [15:0] ir_exp_q[$];

   pc_sequencer dut (
      .clk(clk), .reset(reset), .start(start), .halt_req(halt_req), .pc_cur(pc_cur),
      .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
      .ir(ir), .ir_valid(ir_valid), .exec_done(exec_done), .branch_taken(branch_taken),
      .branch_target(branch_target), .en_pc(en_pc), .in_pc(in_pc), .retired(retired),
      .halted(halted), .fault(fault), .state(state)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cycle++;

   always @(posedge clk or posedge reset) begin
      if (reset)      pc_q_model <= 16'h0000;
      else if (en_pc) pc_q_model <= in_pc;
   end
   assign pc_cur = pc_q_model;

   always @(negedge clk) begin
      if (!reset) begin
         if (en_pc) begin
            n_tests++;
            if (pcload_q.size() == 0) begin
               n_fail++;
               $display("FAIL pc_load: unexpected en_pc with in_pc=%h, none expected", in_pc);
            end else begin
               logic [15:0] e;
               e = pcload_q.pop_front();
               if (in_pc !== e) begin
                  n_fail++;
                  $display("FAIL pc_load: in_pc=%h expected %h", in_pc, e);
               end
            end
         end
         if (ir_valid) begin
            n_tests++;
            if (ir_exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL ir_pulse: unexpected ir_valid with ir=%h", ir);
            end else begin
               logic [15:0] e;
               e = ir_exp_q.pop_front();
               if (ir !== e) begin
                  n_fail++;
                  $display("FAIL ir_word: ir=%h expected %h", ir, e);
               end
            end
         end
      end
   end

   task automatic step();
      @(negedge clk);
   endtask

   task automatic wait_mem_rd(input string tag);
      int n = 0;
      while (mem_rd !== 1'b1 && n < 20) begin
         step();
         n++;
      end
      n_tests++;
      if (mem_rd !== 1'b1) begin
         n_fail++;
         $display("FAIL %s_mem_rd_timeout: mem_rd=%b expected 1 within 20 cycles", tag, mem_rd);
      end
   endtask

   // hmode: 0 none, 1 halt_req during WAIT, 2 halt_req with exec_done
   task automatic run_instr(input logic [15:0] word, input int stall, input int elat,
                            input logic taken, input logic [15:0] tgt, input int hmode);
      logic [15:0] nxt;
      wait_mem_rd("instr");
      n_tests++;
      if (mem_addr !== exp_pc || retired !== exp_retired) begin
         n_fail++;
         $display("FAIL fetch_addr: mem_addr=%h retired=%0d expected %h / %0d",
                  mem_addr, retired, exp_pc, exp_retired);
      end
      halt_req = (hmode == 1);
      for (int i = 0; i < stall; i++) begin
         n_tests++;
         if (mem_rd !== 1'b1 || mem_addr !== exp_pc || fault !== 1'b0 || state !== 3'd3) begin
            n_fail++;
            $display("FAIL stall: mem_rd=%b addr=%h fault=%b state=%0d expected 1 %h 0 3",
                     mem_rd, mem_addr, fault, state, exp_pc);
         end
         step();
      end
      mem_ready = 1'b1;
      mem_rdata = word;
      ir_exp_q.push_back(word);
      step();
      mem_ready = 1'b0;
      halt_req  = 1'b0;
      step();
      for (int i = 0; i < elat; i++) step();
      n_tests++;
      if (state !== 3'd5) begin
         n_fail++;
         $display("FAIL exec_state: state=%0d expected 5", state);
      end
      exec_done     = 1'b1;
      branch_taken  = taken;
      branch_target = tgt;
      halt_req      = (hmode == 2);
      nxt = taken ? tgt : exp_pc + 16'd1;
      pcload_q.push_back(nxt);
      exp_pc = nxt;
      step();
      exec_done    = 1'b0;
      branch_taken = 1'b0;
      halt_req     = 1'b0;
      exp_retired  = exp_retired + 16'd1;
   endtask

   task automatic do_start();
      pcload_q.push_back(16'h0000);
      exp_pc = 16'h0000;
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      step();
      n_tests++;
      if (state !== 3'd0 || mem_rd !== 1'b0 || en_pc !== 1'b0 || retired !== 16'd0 ||
          fault !== 1'b0 || halted !== 1'b0 || ir_valid !== 1'b0 || in_pc !== 16'd0) begin
         n_fail++;
         $display("FAIL reset_state: state=%0d rd=%b en=%b ret=%0d flt=%b hlt=%b iv=%b in_pc=%h expected all 0",
                  state, mem_rd, en_pc, retired, fault, halted, ir_valid, in_pc);
      end
      reset = 1'b0;
      exp_retired = 16'd0;
      step();
   endtask

   task automatic test_start();
      do_start();
      n_tests++;
      if (state !== 3'd1 || en_pc !== 1'b1) begin
         n_fail++;
         $display("FAIL start_vector: state=%0d en_pc=%b expected 1 1", state, en_pc);
      end
      step();
      n_tests++;
      if (state !== 3'd2 || mem_rd !== 1'b0 || en_pc !== 1'b0) begin
         n_fail++;
         $display("FAIL start_fetch: state=%0d mem_rd=%b en_pc=%b expected 2 0 0", state, mem_rd, en_pc);
      end
      step();
      n_tests++;
      if (mem_rd !== 1'b1 || mem_addr !== 16'h0000) begin
         n_fail++;
         $display("FAIL start_first_rd: mem_rd=%b mem_addr=%h expected 1 0000", mem_rd, mem_addr);
      end
      run_instr(16'h1234, 0, 0, 1'b0, 16'h0, 0);
   endtask

   task automatic test_sequential();
      int t0, t1;
      run_instr(16'h0101, 0, 0, 1'b1, 16'h0005, 0);
      t0 = cycle;
      run_instr(16'h0202, 0, 0, 1'b0, 16'h0, 0);
      t1 = cycle;
      n_tests++;
      if (t1 - t0 != 5) begin
         n_fail++;
         $display("FAIL seq_spacing: %0d cycles per instruction, expected 5", t1 - t0);
      end
      run_instr(16'h0303, 0, 0, 1'b1, 16'hFFFF, 0);
      run_instr(16'h0404, 0, 0, 1'b0, 16'h0, 0);
      wait_mem_rd("wrap");
      n_tests++;
      if (mem_addr !== 16'h0000) begin
         n_fail++;
         $display("FAIL pc_wrap: mem_addr=%h expected 0000", mem_addr);
      end
   endtask

   task automatic test_branch();
      run_instr(16'h0505, 0, 2, 1'b1, 16'h00A0, 0);
      run_instr(16'h0606, 3, 1, 1'b0, 16'h0, 0);
      run_instr(16'h0707, 15, 0, 1'b0, 16'h0, 0);
      n_tests++;
      if (fault !== 1'b0) begin
         n_fail++;
         $display("FAIL ready_on_timeout_edge: fault=%b expected 0", fault);
      end
   endtask

   task automatic test_halt();
      run_instr(16'h0808, 1, 0, 1'b0, 16'h0, 1);
      step();
      n_tests++;
      if (halted !== 1'b1 || state !== 3'd7) begin
         n_fail++;
         $display("FAIL halt_after_wait_req: halted=%b state=%0d expected 1 7", halted, state);
      end
      start = 1'b1;
      halt_req = 1'b1;
      step();
      start = 1'b0;
      halt_req = 1'b0;
      n_tests++;
      if (state !== 3'd2 || halted !== 1'b0) begin
         n_fail++;
         $display("FAIL resume_fetch: state=%0d halted=%b expected 2 0", state, halted);
      end
      run_instr(16'h0909, 0, 0, 1'b0, 16'h0, 0);
      step();
      n_tests++;
      if (state !== 3'd2) begin
         n_fail++;
         $display("FAIL halt_dropped: state=%0d expected 2", state);
      end
      run_instr(16'h0A0A, 0, 0, 1'b1, 16'h0040, 2);
      step();
      n_tests++;
      if (halted !== 1'b1 || retired !== exp_retired) begin
         n_fail++;
         $display("FAIL halt_with_exec_done: halted=%b retired=%0d expected 1 %0d", halted, retired, exp_retired);
      end
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic test_timeout();
      wait_mem_rd("tmo");
      for (int i = 0; i < 15; i++) step();
      n_tests++;
      if (state !== 3'd3 || fault !== 1'b0) begin
         n_fail++;
         $display("FAIL tmo_early: state=%0d fault=%b expected 3 0", state, fault);
      end
      step();
      n_tests++;
      if (fault !== 1'b1 || halted !== 1'b1 || state !== 3'd7 || mem_rd !== 1'b0) begin
         n_fail++;
         $display("FAIL tmo_fault: fault=%b halted=%b state=%0d mem_rd=%b expected 1 1 7 0",
                  fault, halted, state, mem_rd);
      end
      start = 1'b1;
      step();
      step();
      start = 1'b0;
      n_tests++;
      if (state !== 3'd7 || fault !== 1'b1) begin
         n_fail++;
         $display("FAIL tmo_start_ignored: state=%0d fault=%b expected 7 1", state, fault);
      end
   endtask

   task automatic test_async_reset();
      test_reset();
      do_start();
      wait_mem_rd("rst_wait");
      #3 reset = 1'b1;
      #1;
      n_tests++;
      if (state !== 3'd0 || mem_rd !== 1'b0 || en_pc !== 1'b0 || retired !== 16'd0 || fault !== 1'b0) begin
         n_fail++;
         $display("FAIL async_reset_wait: state=%0d mem_rd=%b en_pc=%b retired=%0d fault=%b expected 0",
                  state, mem_rd, en_pc, retired, fault);
      end
      step();
      reset = 1'b0;
      exp_retired = 16'd0;
      step();
      do_start();
      run_instr(16'h0B0B, 0, 0, 1'b0, 16'h0, 0);
      #3 reset = 1'b1;
      #1;
      n_tests++;
      if (state !== 3'd0 || mem_rd !== 1'b0 || en_pc !== 1'b0 || retired !== 16'd0) begin
         n_fail++;
         $display("FAIL async_reset_update: state=%0d mem_rd=%b en_pc=%b retired=%0d expected 0",
                  state, mem_rd, en_pc, retired);
      end
      step();
      reset = 1'b0;
      step();
   endtask

   initial begin
      exp_pc = 16'h0000;
      exp_retired = 16'd0;
      test_reset();
      test_start();
      test_sequential();
      test_branch();
      test_halt();
      test_timeout();
      test_async_reset();
      n_tests++;
      if (pcload_q.size() != 0 || ir_exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: %0d pc loads, %0d ir words left, expected 0",
                  pcload_q.size(), ir_exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: bench did not finish");
      $fatal(1);
   end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Instruction-cycle controller that owns the program counter's load port. It steps the CPU through vector/fetch/decode/execute/update, performs the instruction-memory read handshake, and computes the next PC: sequential increment or branch target. It drives `en_pc`/`in_pc` of `program_counter` and reads back its `pc_result`.

## Interface
- `RESET_VECTOR`, 16'h0000: PC loaded on start from IDLE.
- `PC_STEP`, 1: sequential increment.
- `MEM_TIMEOUT`, 16: max WAIT cycles before fault; 0 disables the timeout.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `start` in 1: begin or resume; honored only in IDLE/HALT.
- `halt_req` in 1: request stop at the next instruction boundary.
- `pc_cur` in 16: current PC (`pc_result` of `program_counter`).
- `mem_rd` out 1: instruction read request.
- `mem_addr` out 16: read address.
- `mem_ready` in 1: read data valid.
- `mem_rdata` in 16: instruction word.
- `ir` out 16: instruction register.
- `ir_valid` out 1: one-cycle pulse, decode slot.
- `exec_done` in 1: datapath finished the instruction.
- `branch_taken` in 1: sampled with `exec_done`.
- `branch_target` in 16: sampled with `exec_done`.
- `en_pc` out 1: PC load enable.
- `in_pc` out 16: PC load value.
- `retired` out 16: completed-instruction count, wraps.
- `halted` out 1: in HALT.
- `fault` out 1: memory timeout occurred, sticky.
- `state` out 3: current state.

## Operation
- States: IDLE=0, VECTOR=1, FETCH=2, WAIT=3, DECODE=4, EXEC=5, UPDATE=6, HALT=7.
- Reset (async): state=IDLE; all outputs 0; internal `halt_pending` cleared; timeout count cleared.
- IDLE: `start`=1 → VECTOR.
- VECTOR: `en_pc`=1, `in_pc`=RESET_VECTOR → FETCH.
- FETCH: `mem_addr` ← `pc_cur` → WAIT.
- WAIT:
  - `mem_rd`=1 for every WAIT cycle; `mem_addr` stable.
  - `mem_ready`=1: `ir` ← `mem_rdata` → DECODE.
  - Else, if the count reaches MEM_TIMEOUT (nonzero): `fault`←1 → HALT.
  - `mem_ready` is ignored outside WAIT.
- DECODE: `ir_valid`=1 → EXEC.
- EXEC: wait for `exec_done`. On `exec_done`: next = `branch_taken` ? `branch_target` : (`pc_cur` + PC_STEP) mod 2^16 → UPDATE. 16'hFFFF+1 wraps to 16'h0000.
- UPDATE: `en_pc`=1, `in_pc`=next; `retired`+1 (wraps). Then → HALT if `halt_pending`, else → FETCH.
- HALT:
  - `halted`=1.
  - `start` with `fault`=0 → FETCH; PC is not revectored; `halt_pending` is cleared.
  - With `fault`=1, only `reset` leaves HALT.
- `halt_req` sets `halt_pending` in any state except IDLE/HALT. An in-flight instruction always completes and updates the PC before halting.
- `en_pc` is high only in VECTOR and UPDATE, exactly one cycle each. `in_pc` holds its last value otherwise.

## Timing
- `program_counter` loads at the edge closing the `en_pc` cycle. `pc_cur` is valid in the following FETCH.
- `start` sampled at edge N: VECTOR in cycle N+1, FETCH N+2, first `mem_rd` N+3.
- Zero-wait memory with `exec_done` in the first EXEC cycle: 5 cycles per instruction (FETCH, WAIT, DECODE, EXEC, UPDATE).
- Each extra cycle of `mem_ready` or `exec_done` latency adds one cycle.
- Timeout fires on the MEM_TIMEOUT-th consecutive WAIT cycle without `mem_ready`. `mem_ready` on that same cycle wins: no fault.
- `halt_req` and `exec_done` in the same cycle: the instruction retires, then HALT.
- `start` and `halt_req` together in HALT: resume wins; the halt is dropped.
- Mid-operation `reset`: immediate IDLE. `mem_rd` and `en_pc` drop without waiting for a clock edge.

## Structure
- Package `cpu_ctrl_pkg`: 3-bit state encodings, data width 16, default RESET_VECTOR.
- One sub-module: `mem_timeout_timer`. Inputs: clear/enable. Output: `expired`. Width derived from MEM_TIMEOUT.
- Everything else is a single FSM with registered outputs in `pc_sequencer`.

## Test plan
- Reset then `start`:
  - `en_pc`=1, `in_pc`=0000 one cycle.
  - `mem_rd` 3 cycles after `start`.
  - `pc_cur`=0 gives `mem_addr`=0000.
  - `mem_rdata`=1234 with `mem_ready` gives `ir`=1234 and an `ir_valid` pulse.
- Sequential run, zero-wait, `pc_cur`=0005 → `in_pc`=0006. `pc_cur`=FFFF → `in_pc`=0000. `retired` increments per UPDATE; 5-cycle spacing.
- Branch: `exec_done`=1, `branch_taken`=1, `branch_target`=00A0 → UPDATE with `in_pc`=00A0. Next `mem_addr`=00A0.
- Memory stall 3 cycles → `mem_rd` held 3 cycles, `mem_addr` stable, no fault. Stall 16 cycles with MEM_TIMEOUT=16 → `fault`=1, `halted`=1, `start` ignored.
- `halt_req` pulse during WAIT → instruction completes, `en_pc` pulses, then `halted`=1. `start` → FETCH at the updated PC, with no VECTOR.
- `reset` asserted during WAIT and during UPDATE → asynchronous `state`=0, `mem_rd`=0, `en_pc`=0, `retired`=0 before the next edge.
